// File: rtl/det_sec_param_pkg.sv
// Shared definitions for the parametrised serial sequence detector:
// FSM state encoding and default geometry.
package det_sec_param_pkg;

  typedef enum logic {
    LLENANDO   = 1'b0,
    COMPARANDO = 1'b1
  } estado_t;

  localparam int         ANCHO_DEF      = 4;
  localparam logic [3:0] PATRON_INI_DEF = 4'b1011;
  localparam int         CNT_W_DEF      = 8;

endpackage

// File: rtl/det_sec_param_registro_desplazamiento.sv
// ANCHO-bit MSB-first shift register with enable and synchronous active-low clear.
// Exposes the value the window would take if the current bit were shifted in.
module registro_desplazamiento #(
  parameter int ANCHO = 4
) (
  input  logic             clk,
  input  logic             clr_n_i,
  input  logic             en_i,
  input  logic             dato_i,
  output logic [ANCHO-1:0] siguiente_o
);

  logic [ANCHO-1:0] ventana_q;
  logic [ANCHO-1:0] ventana_d;

  // The oldest bit falls off the top; the newest enters at bit 0.
  assign siguiente_o = (ventana_q << 1) | {{(ANCHO-1){1'b0}}, dato_i};

  always_comb begin
    ventana_d = ventana_q;
    if (en_i) ventana_d = siguiente_o;
  end

  always_ff @(posedge clk) begin
    if (!clr_n_i) ventana_q <= '0;
    else          ventana_q <= ventana_d;
  end

endmodule

// File: rtl/det_sec_param.sv
// Serial pattern detector: shifts in qualified bits, compares the last ANCHO bits
// with a reloadable pattern, supports overlap/non-overlap and counts matches.
module det_sec_param
  import det_sec_param_pkg::*;
#(
  parameter int               ANCHO      = ANCHO_DEF,
  parameter logic [ANCHO-1:0] PATRON_INI = PATRON_INI_DEF,
  parameter int               CNT_W      = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_in,
  input  logic             s_valido,
  input  logic             solape,
  input  logic             cargar,
  input  logic [ANCHO-1:0] patron_in,
  input  logic             limpiar,
  output logic             valido,
  output logic             nuevo_numero,
  output logic [ANCHO-1:0] numero,
  output logic [CNT_W-1:0] cuenta
);

  localparam int             LW       = $clog2(ANCHO + 1);
  localparam logic [LW-1:0]  LLENO    = LW'(ANCHO);
  localparam logic [LW-1:0]  LLENO_M1 = LW'(ANCHO - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  estado_t          estado_q, estado_d;
  logic [LW-1:0]    llenos_q, llenos_d;
  logic [ANCHO-1:0] patron_q, patron_d;
  logic             valido_q, valido_d;
  logic             nuevo_q, nuevo_d;
  logic [ANCHO-1:0] numero_q, numero_d;
  logic [CNT_W-1:0] cuenta_q, cuenta_d;
  logic [ANCHO-1:0] ventana_sig;
  logic             evaluar;
  logic             coincide;

  registro_desplazamiento #(.ANCHO(ANCHO)) u_ventana (
    .clk         (clk),
    .clr_n_i     (rst),
    .en_i        (s_valido),
    .dato_i      (s_in),
    .siguiente_o (ventana_sig)
  );

  assign coincide = (ventana_sig == patron_q);

  always_ff @(posedge clk) begin
    if (!rst) estado_q <= LLENANDO;
    else      estado_q <= estado_d;
  end

  // A non-overlapping match discards the window so ANCHO fresh bits are needed.
  always_comb begin
    estado_d = estado_q;
    if (evaluar) estado_d = (coincide && !solape) ? LLENANDO : COMPARANDO;
  end

  always_comb begin
    evaluar = 1'b0;
    case (estado_q)
      LLENANDO:   evaluar = s_valido && (llenos_q == LLENO_M1);
      COMPARANDO: evaluar = s_valido;
      default:    evaluar = 1'b0;
    endcase
  end

  always_comb begin
    llenos_d = llenos_q;
    if (s_valido) begin
      if (evaluar && coincide && !solape) llenos_d = '0;
      else if (llenos_q != LLENO)         llenos_d = llenos_q + LW'(1);
    end

    patron_d = cargar ? patron_in : patron_q;
    valido_d = evaluar && coincide;
    nuevo_d  = evaluar;
    numero_d = evaluar ? ventana_sig : numero_q;

    // Clearing wins over a same-cycle increment; the pulse itself is unaffected.
    cuenta_d = cuenta_q;
    if (limpiar)                            cuenta_d = '0;
    else if (valido_d && cuenta_q != CNT_MAX) cuenta_d = cuenta_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      llenos_q <= '0;
      patron_q <= PATRON_INI;
      valido_q <= 1'b0;
      nuevo_q  <= 1'b0;
      numero_q <= '0;
      cuenta_q <= '0;
    end else begin
      llenos_q <= llenos_d;
      patron_q <= patron_d;
      valido_q <= valido_d;
      nuevo_q  <= nuevo_d;
      numero_q <= numero_d;
      cuenta_q <= cuenta_d;
    end
  end

  assign valido       = valido_q;
  assign nuevo_numero = nuevo_q;
  assign numero       = numero_q;
  assign cuenta       = cuenta_q;

endmodule
